// File: rtl/axil_slave_regfile.sv
// AXI-Lite register-file slave: REG_COUNT byte-strobed registers, exposed flat on reg_out.
// Optional build macro AXIL_SLAVE_WR_PULSE_EN adds the per-register reg_wr_pulse strobe output.
module axil_slave_regfile #(
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned REG_COUNT      = 16
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]           s_axil_awaddr,
    input  logic                                s_axil_awvalid,
    output logic                                s_axil_awready,
    input  logic [AXI_DATA_WIDTH-1:0]           s_axil_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]         s_axil_wstrb,
    input  logic                                s_axil_wvalid,
    output logic                                s_axil_wready,
    output logic [1:0]                          s_axil_bresp,
    output logic                                s_axil_bvalid,
    input  logic                                s_axil_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]           s_axil_araddr,
    input  logic                                s_axil_arvalid,
    output logic                                s_axil_arready,
    output logic [AXI_DATA_WIDTH-1:0]           s_axil_rdata,
    output logic [1:0]                          s_axil_rresp,
    output logic                                s_axil_rvalid,
    input  logic                                s_axil_rready,
    output logic [REG_COUNT*AXI_DATA_WIDTH-1:0] reg_out
`ifdef AXIL_SLAVE_WR_PULSE_EN
    ,
    output logic [REG_COUNT-1:0]                reg_wr_pulse
`endif
);

    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB   = $clog2(STRB_WIDTH);
    localparam logic [AXI_ADDR_WIDTH-1:0] REG_LIMIT = AXI_ADDR_WIDTH'(REG_COUNT);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {WIdle, WResp} w_state_e;
    typedef enum logic [0:0] {RIdle, RData} r_state_e;

    logic [AXI_DATA_WIDTH-1:0] regs_q [REG_COUNT];

    // Write channel state
    w_state_e                  w_state_q, w_state_d;
    logic                      aw_held_q, aw_held_d;
    logic                      w_held_q, w_held_d;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]     wstrb_q, wstrb_d;
    logic                      awready_q, awready_d;
    logic                      wready_q, wready_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;

    // Read channel state
    r_state_e                  r_state_q, r_state_d;
    logic                      arready_q, arready_d;
    logic                      rvalid_q, rvalid_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                      aw_hs, w_hs, ar_hs;
    logic                      aw_have, w_have;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr, wr_idx, rd_idx;
    logic [AXI_DATA_WIDTH-1:0] wr_data, rd_word;
    logic [STRB_WIDTH-1:0]     wr_strb;
    logic                      wr_hit, rd_hit, wr_en;
    logic [REG_COUNT-1:0]      wr_sel;

    assign aw_hs   = s_axil_awvalid && awready_q;
    assign w_hs    = s_axil_wvalid && wready_q;
    assign ar_hs   = s_axil_arvalid && arready_q;
    assign aw_have = aw_held_q || aw_hs;
    assign w_have  = w_held_q || w_hs;

    // A same-edge handshake bypasses the holding register.
    assign wr_addr = aw_hs ? s_axil_awaddr : awaddr_q;
    assign wr_data = w_hs ? s_axil_wdata : wdata_q;
    assign wr_strb = w_hs ? s_axil_wstrb : wstrb_q;
    assign wr_idx  = wr_addr >> ADDR_LSB;
    assign wr_hit  = wr_idx < REG_LIMIT;
    assign rd_idx  = s_axil_araddr >> ADDR_LSB;
    assign rd_hit  = rd_idx < REG_LIMIT;

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_en     = 1'b0;
        case (w_state_q)
            WIdle: begin
                if (aw_have && w_have) begin
                    wr_en     = wr_hit;
                    bvalid_d  = 1'b1;
                    bresp_d   = wr_hit ? RESP_OKAY : RESP_SLVERR;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    w_state_d = WResp;
                end else begin
                    aw_held_d = aw_have;
                    w_held_d  = w_have;
                    if (aw_hs) begin
                        awaddr_d = s_axil_awaddr;
                    end
                    if (w_hs) begin
                        wdata_d = s_axil_wdata;
                        wstrb_d = s_axil_wstrb;
                    end
                    awready_d = !aw_have;
                    wready_d  = !w_have;
                end
            end
            WResp: begin
                awready_d = 1'b0;
                wready_d  = 1'b0;
                if (s_axil_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    always_comb begin
        wr_sel = '0;
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
            wr_sel[i] = wr_en && (wr_idx == AXI_ADDR_WIDTH'(i));
        end
    end

    // Read mux returns zero on a miss since no index matches.
    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
            if (rd_idx == AXI_ADDR_WIDTH'(i)) begin
                rd_word = regs_q[i];
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            RIdle: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    rdata_d   = rd_word;
                    rresp_d   = rd_hit ? RESP_OKAY : RESP_SLVERR;
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    r_state_d = RData;
                end
            end
            RData: begin
                arready_d = 1'b0;
                if (s_axil_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = RIdle;
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= WIdle;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            r_state_q <= RIdle;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
                    if (wr_sel[i] && wr_strb[b]) begin
                        regs_q[i][b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < REG_COUNT; g++) begin : g_reg_out
        assign reg_out[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs_q[g];
    end

`ifdef AXIL_SLAVE_WR_PULSE_EN
    logic [REG_COUNT-1:0] wr_pulse_q;

    // wr_sel is only non-zero on the edge that raises bvalid, so this is a one-cycle strobe.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= wr_sel;
        end
    end

    assign reg_wr_pulse = wr_pulse_q;
`else
    // No strobe output in this build; wr_sel only steers the register bank.
`endif

    assign s_axil_awready = awready_q;
    assign s_axil_wready  = wready_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = arready_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rdata   = rdata_q;

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Directed self-checking bench for axil_slave_regfile (32-bit data, 16 registers).
module tb_axil_slave_regfile;

    logic         aclk;
    logic         aresetn;
    logic [31:0]  awaddr;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [31:0]  araddr;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [511:0] reg_out;
`ifdef AXIL_SLAVE_WR_PULSE_EN
    logic [15:0]  reg_wr_pulse;
`endif

    int total;
    int bad;
    logic [511:0] exp_flat;

    axil_slave_regfile #(
        .AXI_DATA_WIDTH(32),
        .AXI_ADDR_WIDTH(32),
        .REG_COUNT(16)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .s_axil_awaddr(awaddr),
        .s_axil_awvalid(awvalid),
        .s_axil_awready(awready),
        .s_axil_wdata(wdata),
        .s_axil_wstrb(wstrb),
        .s_axil_wvalid(wvalid),
        .s_axil_wready(wready),
        .s_axil_bresp(bresp),
        .s_axil_bvalid(bvalid),
        .s_axil_bready(bready),
        .s_axil_araddr(araddr),
        .s_axil_arvalid(arvalid),
        .s_axil_arready(arready),
        .s_axil_rdata(rdata),
        .s_axil_rresp(rresp),
        .s_axil_rvalid(rvalid),
        .s_axil_rready(rready),
        .reg_out(reg_out)
`ifdef AXIL_SLAVE_WR_PULSE_EN
        ,
        .reg_wr_pulse(reg_wr_pulse)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        aresetn = 1'b0;
        awaddr = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b1;
        araddr = '0; arvalid = 1'b0;
        rready = 1'b1;
        exp_flat = '0;

        // Reset state
        tick();
        chk("rst_awready", 512'(awready), 512'(0));
        chk("rst_wready", 512'(wready), 512'(0));
        chk("rst_arready", 512'(arready), 512'(0));
        chk("rst_bvalid", 512'(bvalid), 512'(0));
        chk("rst_rvalid", 512'(rvalid), 512'(0));
        chk("rst_rdata", 512'(rdata), 512'(0));
        chk("rst_reg_out", reg_out, 512'(0));
        aresetn = 1'b1;
        tick();
        chk("rel_awready", 512'(awready), 512'(1));
        chk("rel_wready", 512'(wready), 512'(1));
        chk("rel_arready", 512'(arready), 512'(1));

        // 1: AW and W in the same cycle
        awaddr = 32'h08; awvalid = 1'b1;
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        exp_flat[2*32 +: 32] = 32'hDEADBEEF;
        chk("t1_bvalid", 512'(bvalid), 512'(1));
        chk("t1_bresp", 512'(bresp), 512'(0));
        chk("t1_awready", 512'(awready), 512'(0));
        chk("t1_reg_out", reg_out, exp_flat);
        tick();
        chk("t1_bvalid_drop", 512'(bvalid), 512'(0));
        chk("t1_awready_back", 512'(awready), 512'(1));

        // 2: W three cycles ahead of AW, partial strobe
        wdata = 32'h11223344; wstrb = 4'h5; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("t2_wready_held", 512'(wready), 512'(0));
        chk("t2_awready", 512'(awready), 512'(1));
        tick();
        tick();
        chk("t2_no_early_b", 512'(bvalid), 512'(0));
        awaddr = 32'h0C; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        exp_flat[3*32 +: 32] = 32'h00220044;
        chk("t2_bvalid", 512'(bvalid), 512'(1));
        chk("t2_bresp", 512'(bresp), 512'(0));
        chk("t2_reg_out", reg_out, exp_flat);
        tick();
        chk("t2_bvalid_drop", 512'(bvalid), 512'(0));

        // 3: out-of-range write and read
        awaddr = 32'h40; awvalid = 1'b1;
        wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 32'h40; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("t3_bresp", 512'(bresp), 512'(2));
        chk("t3_rvalid", 512'(rvalid), 512'(1));
        chk("t3_rresp", 512'(rresp), 512'(2));
        chk("t3_rdata", 512'(rdata), 512'(0));
        chk("t3_reg_out", reg_out, exp_flat);
        tick();
        chk("t3_rvalid_drop", 512'(rvalid), 512'(0));
        chk("t3_arready_back", 512'(arready), 512'(1));

        // 4: read held under rready back-pressure
        rready = 1'b0;
        araddr = 32'h08; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t4_rvalid_hold", 512'(rvalid), 512'(1));
            chk("t4_rdata_hold", 512'(rdata), 512'(32'hDEADBEEF));
            chk("t4_rresp_hold", 512'(rresp), 512'(0));
            chk("t4_arready_low", 512'(arready), 512'(0));
            tick();
        end
        rready = 1'b1;
        tick();
        chk("t4_rvalid_drop", 512'(rvalid), 512'(0));
        chk("t4_arready_back", 512'(arready), 512'(1));

        // Same-edge read and write of one register: read sees the old value
        awaddr = 32'h0C; awvalid = 1'b1;
        wdata = 32'hAAAAAAAA; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 32'h0C; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        exp_flat[3*32 +: 32] = 32'hAAAAAAAA;
        chk("rw_rdata_old", 512'(rdata), 512'(32'h00220044));
        chk("rw_reg_out", reg_out, exp_flat);
        tick();

        // bresp held while bready is low; wstrb=0 changes nothing
        bready = 1'b0;
        awaddr = 32'h08; awvalid = 1'b1;
        wdata = 32'h12345678; wstrb = 4'h0; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_bvalid_hold", 512'(bvalid), 512'(1));
            chk("bp_bresp_hold", 512'(bresp), 512'(0));
            chk("bp_awready_low", 512'(awready), 512'(0));
            tick();
        end
        chk("bp_strb0_reg_out", reg_out, exp_flat);
        bready = 1'b1;
        tick();
        chk("bp_bvalid_drop", 512'(bvalid), 512'(0));

        // 5: reset between AW and W drops the pending write
        awaddr = 32'h10; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("t5_aw_held", 512'(awready), 512'(0));
        #3 aresetn = 1'b0;
        #1;
        exp_flat = '0;
        chk("t5_awready", 512'(awready), 512'(0));
        chk("t5_wready", 512'(wready), 512'(0));
        chk("t5_arready", 512'(arready), 512'(0));
        chk("t5_bvalid", 512'(bvalid), 512'(0));
        chk("t5_rdata", 512'(rdata), 512'(0));
        chk("t5_reg_out", reg_out, exp_flat);
        #2 aresetn = 1'b1;
        tick();
        chk("t5_awready_rel", 512'(awready), 512'(1));
        wdata = 32'h55AA55AA; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("t5_w_only_no_b", 512'(bvalid), 512'(0));
        awaddr = 32'h14; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        exp_flat[5*32 +: 32] = 32'h55AA55AA;
        chk("t5_bvalid", 512'(bvalid), 512'(1));
        chk("t5_bresp", 512'(bresp), 512'(0));
        chk("t5_reg_out", reg_out, exp_flat);
        tick();

`ifdef AXIL_SLAVE_WR_PULSE_EN
        // 6: write strobe
        chk("t6_pulse_idle", 512'(reg_wr_pulse), 512'(0));
        awaddr = 32'h04; awvalid = 1'b1;
        wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("t6_pulse_hit", 512'(reg_wr_pulse), 512'(16'h0002));
        tick();
        chk("t6_pulse_gone", 512'(reg_wr_pulse), 512'(0));
        awaddr = 32'h40; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk("t6_pulse_miss", 512'(reg_wr_pulse), 512'(0));
        chk("t6_miss_bresp", 512'(bresp), 512'(2));
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
